// File: rtl/tuner_phy_ctrl_arb_nch.sv
// Tuner PHY controller with N-channel arbitration.
// One channel at a time wins the tuner. Its code is driven to the DAC, the
// path is allowed to settle, a power sample is requested, and the owner
// receives either the captured power with an ack or a timeout error.
module tuner_phy_ctrl_arb_nch #(
    parameter int NUM_CH      = 2,
    parameter int CODE_WIDTH  = 8,
    parameter int PWR_WIDTH   = 8,
    parameter int SYNC_CYCLES = 4,
    parameter int PWR_TIMEOUT = 64,
    parameter int PRIO_MODE   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            ch_req_i,
    input  logic [NUM_CH*CODE_WIDTH-1:0] ch_code_i,
    output logic [NUM_CH-1:0]            ch_grant_o,
    output logic [NUM_CH-1:0]            ch_ack_o,
    output logic [NUM_CH-1:0]            ch_err_o,
    output logic [PWR_WIDTH-1:0]         ch_pwr_o,
    output logic [CODE_WIDTH-1:0]        tuner_code_o,
    output logic                         tuner_valid_o,
    output logic                         pwr_req_o,
    input  logic [PWR_WIDTH-1:0]         pwr_i,
    input  logic                         pwr_valid_i,
    output logic [1:0]                   state_o
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SET_W = $clog2(SYNC_CYCLES) + 1;
    localparam int TMO_W = $clog2(PWR_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_TUNE   = 2'b01,
        ST_SYNC   = 2'b10,
        ST_COMMIT = 2'b11
    } state_t;

    state_t                  state_q,      state_d;
    logic [CODE_WIDTH-1:0]   tuner_code_q, tuner_code_d;
    logic                    tuner_valid_q, tuner_valid_d;
    logic                    pwr_req_q,    pwr_req_d;
    logic [NUM_CH-1:0]       grant_q,      grant_d;
    logic [NUM_CH-1:0]       ack_q,        ack_d;
    logic [NUM_CH-1:0]       err_q,        err_d;
    logic [PWR_WIDTH-1:0]    ch_pwr_q,     ch_pwr_d;
    logic [CH_W-1:0]         rr_ptr_q,     rr_ptr_d;
    logic [CH_W-1:0]         owner_q,      owner_d;
    logic [SET_W-1:0]        set_cnt_q,    set_cnt_d;
    logic [TMO_W-1:0]        tmo_cnt_q,    tmo_cnt_d;

    logic [CODE_WIDTH-1:0]   code_arr [NUM_CH];
    logic                    win_vld;
    logic [CH_W-1:0]         win_idx;
    logic [CH_W-1:0]         cand;
    logic [CH_W-1:0]         owner_nxt;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_code
        assign code_arr[k] = ch_code_i[k*CODE_WIDTH +: CODE_WIDTH];
    end

    // Round-robin pointer advances past the owner once it is released.
    assign owner_nxt = (int'(owner_q) == NUM_CH - 1) ? '0 : owner_q + 1'b1;

    // Arbiter: scan from rr_ptr (round-robin) or from channel 0 (fixed priority).
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (PRIO_MODE == 1) cand = CH_W'(i);
            else                cand = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
            if (!win_vld && ch_req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d       = state_q;
        tuner_code_d  = tuner_code_q;
        tuner_valid_d = 1'b0;
        pwr_req_d     = pwr_req_q;
        grant_d       = grant_q;
        ack_d         = '0;
        err_d         = '0;
        ch_pwr_d      = ch_pwr_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        set_cnt_d     = set_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (win_vld) begin
                    state_d       = ST_TUNE;
                    owner_d       = win_idx;
                    grant_d       = NUM_CH'(1) << win_idx;
                    tuner_code_d  = code_arr[win_idx];
                    tuner_valid_d = 1'b1;
                end
            end
            ST_TUNE: begin
                state_d   = ST_SYNC;
                set_cnt_d = '0;
                tmo_cnt_d = '0;
                pwr_req_d = (SYNC_CYCLES == 0);
            end
            ST_SYNC: begin
                if (|err_q) begin
                    // Timeout cycle has been presented; release the owner.
                    state_d  = ST_INIT;
                    grant_d  = '0;
                    rr_ptr_d = owner_nxt;
                end else if (!pwr_req_q) begin
                    if (int'(set_cnt_q) + 1 >= SYNC_CYCLES) pwr_req_d = 1'b1;
                    if (set_cnt_q != '1) set_cnt_d = set_cnt_q + 1'b1;
                end else if (pwr_valid_i) begin
                    state_d   = ST_COMMIT;
                    ch_pwr_d  = pwr_i;
                    pwr_req_d = 1'b0;
                    ack_d     = grant_q;
                end else if (int'(tmo_cnt_q) + 1 >= PWR_TIMEOUT) begin
                    pwr_req_d = 1'b0;
                    err_d     = grant_q;
                end else if (tmo_cnt_q != '1) begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_INIT;
                grant_d  = '0;
                rr_ptr_d = owner_nxt;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_INIT;
            tuner_code_q  <= '0;
            tuner_valid_q <= 1'b0;
            pwr_req_q     <= 1'b0;
            grant_q       <= '0;
            ack_q         <= '0;
            err_q         <= '0;
            ch_pwr_q      <= '0;
            rr_ptr_q      <= '0;
            owner_q       <= '0;
            set_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            tuner_code_q  <= tuner_code_d;
            tuner_valid_q <= tuner_valid_d;
            pwr_req_q     <= pwr_req_d;
            grant_q       <= grant_d;
            ack_q         <= ack_d;
            err_q         <= err_d;
            ch_pwr_q      <= ch_pwr_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            set_cnt_q     <= set_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign ch_grant_o    = grant_q;
    assign ch_ack_o      = ack_q;
    assign ch_err_o      = err_q;
    assign ch_pwr_o      = ch_pwr_q;
    assign tuner_code_o  = tuner_code_q;
    assign tuner_valid_o = tuner_valid_q;
    assign pwr_req_o     = pwr_req_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_tuner_phy_ctrl_arb_nch.sv
// Directed bench for tuner_phy_ctrl_arb_nch: three instances (round-robin,
// fixed priority, 4-channel with zero settle) share one stimulus path
// selected by 'sel'; acks are checked against a scoreboard queue.
module tb_tuner_phy_ctrl_arb_nch;

    logic clk;
    logic rst_n;
    int   sel;

    logic [3:0]  req;
    logic [31:0] code;
    logic [7:0]  pwr;
    logic        pvld;

    // Instance A: defaults (NUM_CH=2, round-robin, SYNC_CYCLES=4, PWR_TIMEOUT=64)
    logic [1:0]  a_req, a_grant, a_ack, a_err;
    logic [15:0] a_code;
    logic [7:0]  a_cpwr, a_tcode;
    logic        a_tvld, a_preq, a_pvld;
    logic [1:0]  a_state;
    // Instance B: fixed priority
    logic [1:0]  b_req, b_grant, b_ack, b_err;
    logic [15:0] b_code;
    logic [7:0]  b_cpwr, b_tcode;
    logic        b_tvld, b_preq, b_pvld;
    logic [1:0]  b_state;
    // Instance C: NUM_CH=4, SYNC_CYCLES=0
    logic [3:0]  c_req, c_grant, c_ack, c_err;
    logic [31:0] c_code;
    logic [7:0]  c_cpwr, c_tcode;
    logic        c_tvld, c_preq, c_pvld;
    logic [1:0]  c_state;

    // Observed outputs of the selected instance
    logic [3:0] o_grant, o_ack, o_err;
    logic [7:0] o_cpwr, o_tcode;
    logic       o_tvld, o_preq;
    logic [1:0] o_state;

    typedef struct {
        logic [3:0] grant;
        logic [7:0] pwr;
    } exp_t;
    exp_t sb[$];

    int n_chk;
    int n_pass;

    assign a_req  = (sel == 0) ? req[1:0] : 2'b00;
    assign b_req  = (sel == 1) ? req[1:0] : 2'b00;
    assign c_req  = (sel == 2) ? req : 4'b0000;
    assign a_code = code[15:0];
    assign b_code = code[15:0];
    assign c_code = code;
    assign a_pvld = (sel == 0) && pvld;
    assign b_pvld = (sel == 1) && pvld;
    assign c_pvld = (sel == 2) && pvld;

    tuner_phy_ctrl_arb_nch u_a (
        .clk(clk), .rst_n(rst_n), .ch_req_i(a_req), .ch_code_i(a_code),
        .ch_grant_o(a_grant), .ch_ack_o(a_ack), .ch_err_o(a_err), .ch_pwr_o(a_cpwr),
        .tuner_code_o(a_tcode), .tuner_valid_o(a_tvld), .pwr_req_o(a_preq),
        .pwr_i(pwr), .pwr_valid_i(a_pvld), .state_o(a_state)
    );

    tuner_phy_ctrl_arb_nch #(.PRIO_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .ch_req_i(b_req), .ch_code_i(b_code),
        .ch_grant_o(b_grant), .ch_ack_o(b_ack), .ch_err_o(b_err), .ch_pwr_o(b_cpwr),
        .tuner_code_o(b_tcode), .tuner_valid_o(b_tvld), .pwr_req_o(b_preq),
        .pwr_i(pwr), .pwr_valid_i(b_pvld), .state_o(b_state)
    );

    tuner_phy_ctrl_arb_nch #(.NUM_CH(4), .SYNC_CYCLES(0), .PWR_TIMEOUT(8)) u_c (
        .clk(clk), .rst_n(rst_n), .ch_req_i(c_req), .ch_code_i(c_code),
        .ch_grant_o(c_grant), .ch_ack_o(c_ack), .ch_err_o(c_err), .ch_pwr_o(c_cpwr),
        .tuner_code_o(c_tcode), .tuner_valid_o(c_tvld), .pwr_req_o(c_preq),
        .pwr_i(pwr), .pwr_valid_i(c_pvld), .state_o(c_state)
    );

    always_comb begin
        o_grant = {2'b00, a_grant};
        o_ack   = {2'b00, a_ack};
        o_err   = {2'b00, a_err};
        o_cpwr  = a_cpwr;
        o_tcode = a_tcode;
        o_tvld  = a_tvld;
        o_preq  = a_preq;
        o_state = a_state;
        if (sel == 1) begin
            o_grant = {2'b00, b_grant};
            o_ack   = {2'b00, b_ack};
            o_err   = {2'b00, b_err};
            o_cpwr  = b_cpwr;
            o_tcode = b_tcode;
            o_tvld  = b_tvld;
            o_preq  = b_preq;
            o_state = b_state;
        end else if (sel == 2) begin
            o_grant = c_grant;
            o_ack   = c_ack;
            o_err   = c_err;
            o_cpwr  = c_cpwr;
            o_tcode = c_tcode;
            o_tvld  = c_tvld;
            o_preq  = c_preq;
            o_state = c_state;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Scoreboard consumer: every ack pops one expected entry.
    always @(negedge clk) begin
        if (rst_n && o_ack !== 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {28'd0, o_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_ack", {28'd0, o_ack}, {28'd0, e.grant});
                chk("sb_pwr", {24'd0, o_cpwr}, {24'd0, e.pwr});
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, {30'd0, o_state}, 32'd0);
        chk({tag, "_grant"}, {28'd0, o_grant}, 32'd0);
        chk({tag, "_ack"},   {28'd0, o_ack},   32'd0);
        chk({tag, "_err"},   {28'd0, o_err},   32'd0);
        chk({tag, "_cpwr"},  {24'd0, o_cpwr},  32'd0);
        chk({tag, "_tcode"}, {24'd0, o_tcode}, 32'd0);
        chk({tag, "_tvld_preq"}, {30'd0, o_tvld, o_preq}, 32'd0);
    endtask

    // One complete transaction; entered and left at a negedge in INIT.
    task automatic txn(input string tag, input logic [3:0] r, input logic [31:0] codes,
                       input logic [7:0] p, input logic [3:0] exp_g,
                       input logic [7:0] exp_code, input int sync_n, input bit drop);
        exp_t e;
        chk({tag, "_idle"}, {30'd0, o_state}, 32'd0);
        req  = r;
        code = codes;
        @(negedge clk);
        chk({tag, "_tune_state"}, {30'd0, o_state}, 32'd1);
        chk({tag, "_tune_strobe"}, {23'd0, o_tvld, o_tcode}, {23'd0, 1'b1, exp_code});
        chk({tag, "_grant"}, {28'd0, o_grant}, {28'd0, exp_g});
        if (drop) begin
            req  = 4'b0000;
            code = ~codes;
        end
        for (int i = 0; i < sync_n; i++) begin
            @(negedge clk);
            chk({tag, "_settle"}, {29'd0, o_state, o_preq}, {29'd0, 2'b10, 1'b0});
        end
        @(negedge clk);
        chk({tag, "_preq_rise"}, {29'd0, o_state, o_preq}, {29'd0, 2'b10, 1'b1});
        pvld    = 1'b1;
        pwr     = p;
        e.grant = exp_g;
        e.pwr   = p;
        sb.push_back(e);
        @(negedge clk);
        pvld = 1'b0;
        chk({tag, "_commit"}, {30'd0, o_state}, 32'd3);
        chk({tag, "_hold_code"}, {20'd0, o_grant, o_tcode}, {20'd0, exp_g, exp_code});
        @(negedge clk);
        chk({tag, "_release"}, {18'd0, o_state, o_grant, o_ack, o_preq, o_tvld},
            {18'd0, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk  = 0;
        n_pass = 0;
        sel    = 0;
        req    = 4'b0000;
        code   = 32'd0;
        pwr    = 8'd0;
        pvld   = 1'b0;
        rst_n  = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_rst");

        // Round-robin contention, back-to-back: grants 01, 10, 01
        txn("rr0", 4'b0011, 32'h0000_2211, 8'h40, 4'b0001, 8'h11, 4, 1'b0);
        txn("rr1", 4'b0011, 32'h0000_2211, 8'h41, 4'b0010, 8'h22, 4, 1'b0);
        txn("rr2", 4'b0011, 32'h0000_2211, 8'h42, 4'b0001, 8'h11, 4, 1'b0);
        req = 4'b0000;
        @(negedge clk);

        // Single request on channel 0: code 0x5A, power 0x33
        txn("single", 4'b0001, 32'h0000_775A, 8'h33, 4'b0001, 8'h5A, 4, 1'b0);
        req = 4'b0000;
        @(negedge clk);

        // Request dropped and code changed mid-transaction on channel 1
        txn("drop", 4'b0010, 32'h0000_C300, 8'h7E, 4'b0010, 8'hC3, 4, 1'b1);
        @(negedge clk);

        // Timeout: pwr_valid_i never arrives
        req  = 4'b0001;
        code = 32'h0000_0099;
        @(negedge clk);
        chk("tmo_tune", {26'd0, o_state, o_grant}, {26'd0, 2'b01, 4'b0001});
        req = 4'b0000;
        repeat (4) @(negedge clk);
        @(negedge clk);
        chk("tmo_preq_rise", {31'd0, o_preq}, 32'd1);
        for (int k = 1; k < 64; k++) begin
            @(negedge clk);
            chk("tmo_wait", {27'd0, o_preq, o_err}, {27'd0, 1'b1, 4'b0000});
        end
        @(negedge clk);
        chk("tmo_err", {22'd0, o_state, o_preq, o_err}, {22'd0, 2'b10, 1'b0, 4'b0001} << 4 >> 4);
        chk("tmo_err_grant", {28'd0, o_grant}, 32'd1);
        chk("tmo_pwr_kept", {24'd0, o_cpwr}, 32'h7E);
        @(negedge clk);
        chk("tmo_back_init", {22'd0, o_state, o_grant, o_err}, 32'd0);

        // Reset asserted during SYNC
        req  = 4'b0001;
        code = 32'h0000_0044;
        @(negedge clk);
        chk("rstmid_tune", {30'd0, o_state}, 32'd1);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_sync", {30'd0, o_state}, 32'd2);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rstmid_quiet", {26'd0, o_state, o_ack}, 32'd0);
        end

        // Fixed priority: every grant to channel 0
        sel = 1;
        @(negedge clk);
        txn("fp0", 4'b0011, 32'h0000_2211, 8'h51, 4'b0001, 8'h11, 4, 1'b0);
        txn("fp1", 4'b0011, 32'h0000_2211, 8'h52, 4'b0001, 8'h11, 4, 1'b0);
        txn("fp2", 4'b0011, 32'h0000_2211, 8'h53, 4'b0001, 8'h11, 4, 1'b0);
        req = 4'b0000;
        @(negedge clk);

        // Four channels, zero settle: rotation through all channels
        sel = 2;
        @(negedge clk);
        txn("n4_0", 4'b1111, 32'h4433_2211, 8'h61, 4'b0001, 8'h11, 0, 1'b0);
        txn("n4_1", 4'b1111, 32'h4433_2211, 8'h62, 4'b0010, 8'h22, 0, 1'b0);
        txn("n4_2", 4'b1111, 32'h4433_2211, 8'h63, 4'b0100, 8'h33, 0, 1'b0);
        txn("n4_3", 4'b1111, 32'h4433_2211, 8'h64, 4'b1000, 8'h44, 0, 1'b0);
        req = 4'b0000;
        @(negedge clk);
        @(negedge clk);

        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
